fifo_uart_tx_bridge: RTL and testbench

Downstream consumer of the OV7670 pixel FIFO. It pops 16-bit RGB565 words from the FIFO read port whenever the FIFO is non-empty. Each word is serialised as two 8N1 UART bytes, high byte first, on a single TX line to the host PC. It pairs with the capture block, which stops refilling the FIFO until it drains; a frame is complete when 76800 words have been sent.

---
 rtl/fifo_uart_tx_bridge.sv | 178 +++++++++++++++++
 tb/tb_fifo_uart_tx_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_bridge.sv
// rtl/fifo_uart_tx_bridge.sv - pops RGB565 words from the pixel FIFO and sends each as two 8N1 UART bytes
//
// Ports:
//   S_CLK        system clock (FIFO read clock is the same clock)
//   RST_N        asynchronous active-low reset
//   r_empty      FIFO empty flag, read side
//   r_data       FIFO read data, valid the cycle after r_req
//   r_req        FIFO read request, one-cycle pulse per word
//   frame_start  one-cycle pulse at the start of a new frame
//   uart_tx      UART serial output, idle high
//   busy         high whenever the bridge is not idle
//   words_sent   words fully transmitted in the current frame (wraps mod 2^17)
//   frame_done   one-cycle pulse when words_sent reaches IMAGE_WORDS
//
// Parameters: BAUD_DIV (S_CLK cycles per bit, 2..65535), IMAGE_WORDS (words per frame).
// Optional macro FRAME_HEADER_EN: frame_start queues a 0x01, 0xFE header ahead of pixel data.

module fifo_uart_tx_bridge #(
  parameter int BAUD_DIV    = 434,
  parameter int IMAGE_WORDS = 76800
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        r_empty,
  input  logic [15:0] r_data,
  output logic        r_req,
  input  logic        frame_start,
  output logic        uart_tx,
  output logic        busy,
  output logic [16:0] words_sent,
  output logic        frame_done
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [16:0] IMG_WORDS = 17'(IMAGE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_HI,
    SEND_LO
`ifdef FRAME_HEADER_EN
    , HDR
`endif
  } state_t;

  state_t      state;
  logic [15:0] word;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  cur_byte;
  logic        bit_end;
  logic        byte_end;
  logic        word_done;

`ifdef FRAME_HEADER_EN
  logic        header_pending;
  logic        hdr_second;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign byte_end  = bit_end && (bit_cnt == 4'd9);
  assign word_done = (state == SEND_LO) && byte_end;

  always_comb begin
    cur_byte = word[7:0];
    if (state == SEND_HI) cur_byte = word[15:8];
`ifdef FRAME_HEADER_EN
    if (state == HDR) cur_byte = hdr_second ? 8'hFE : 8'h01;
`endif
  end

  // uart_tx is registered: each bit value is loaded on the edge that starts
  // the bit, so the start bit appears on the first cycle of a send state.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      r_req    <= 1'b0;
      busy     <= 1'b0;
      uart_tx  <= 1'b1;
      word     <= 16'h0000;
      baud_cnt <= 16'h0000;
      bit_cnt  <= 4'd0;
`ifdef FRAME_HEADER_EN
      hdr_second <= 1'b0;
`endif
    end else begin
      r_req <= 1'b0;
      case (state)
        IDLE: begin
`ifdef FRAME_HEADER_EN
          if (header_pending) begin
            state      <= HDR;
            busy       <= 1'b1;
            uart_tx    <= 1'b0;
            baud_cnt   <= 16'h0000;
            bit_cnt    <= 4'd0;
            hdr_second <= 1'b0;
          end else
`endif
          if (!r_empty) begin
            state <= FETCH;
            busy  <= 1'b1;
            r_req <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          word     <= r_data;
          state    <= SEND_HI;
          uart_tx  <= 1'b0;
          baud_cnt <= 16'h0000;
          bit_cnt  <= 4'd0;
        end
        default: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + 16'd1;
          end else begin
            baud_cnt <= 16'h0000;
            if (bit_cnt != 4'd9) begin
              // bit_cnt 0 is the start bit, so data bit i follows bit_cnt i.
              bit_cnt <= bit_cnt + 4'd1;
              uart_tx <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
            end else begin
              bit_cnt <= 4'd0;
              if (state == SEND_HI) begin
                state   <= SEND_LO;
                uart_tx <= 1'b0;
              end
`ifdef FRAME_HEADER_EN
              else if (state == HDR && !hdr_second) begin
                hdr_second <= 1'b1;
                uart_tx    <= 1'b0;
              end
`endif
              else begin
                state   <= IDLE;
                busy    <= 1'b0;
                uart_tx <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // frame_start clears the count and wins over a simultaneous increment.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      words_sent <= 17'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        words_sent <= 17'd0;
      end else if (word_done) begin
        words_sent <= words_sent + 17'd1;
        frame_done <= ((words_sent + 17'd1) == IMG_WORDS);
      end
    end
  end

`ifdef FRAME_HEADER_EN
  // Set wins over the clear that happens on HDR entry.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      header_pending <= 1'b0;
    end else if (frame_start) begin
      header_pending <= 1'b1;
    end else if (state == IDLE) begin
      header_pending <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx_bridge.sv
// tb/tb_fifo_uart_tx_bridge.sv - randomized self-checking bench for fifo_uart_tx_bridge
//
// The reference model turns each accepted word (or header) into the expected
// per-cycle line waveform from the 8N1 frame format and compares every cycle.

module tb_fifo_uart_tx_bridge;

  localparam int          B   = 4;
  localparam logic [16:0] IMG = 17'd4;

  typedef struct packed {
    logic tx;
    logic rreq;
    logic busy;
    logic done;
  } exp_t;

  logic        S_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        r_empty = 1'b1;
  logic [15:0] r_data = 16'h0000;
  logic        r_req;
  logic        frame_start = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic [16:0] words_sent;
  logic        frame_done;

  fifo_uart_tx_bridge #(.BAUD_DIV(B), .IMAGE_WORDS(4)) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .r_empty(r_empty), .r_data(r_data),
    .r_req(r_req), .frame_start(frame_start), .uart_tx(uart_tx),
    .busy(busy), .words_sent(words_sent), .frame_done(frame_done)
  );

  always #5 S_CLK = ~S_CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] fifo_q[$];
  logic [16:0] exp_ws = 17'd0;
  logic        exp_fd = 1'b0;
  logic        m_pending = 1'b0;
  logic        hold_data = 1'b0;
  logic        fs_req = 1'b0;
  logic        fs_at_done = 1'b0;
  logic [16:0] fs_at_ws = 17'd0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk17(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected waveform of one 8N1 byte; last marks the final cycle of a word.
  task automatic sched_byte(input logic [7:0] b, input logic last);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < B; c++)
        exp_q.push_back('{frame[i], 1'b0, 1'b1, (last && i == 9 && c == B - 1)});
  endtask

  task automatic step();
    exp_t e;
    logic idle_c;
    @(negedge S_CLK);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idle_c = 1'b0;
    end else begin
      e = '{1'b1, 1'b0, 1'b0, 1'b0};
      idle_c = 1'b1;
    end
    chk1("uart_tx", uart_tx, e.tx);
    chk1("r_req", r_req, e.rreq);
    chk1("busy", busy, e.busy);
    chk17("words_sent", words_sent, exp_ws);
    chk1("frame_done", frame_done, exp_fd);

    // FIFO responder: data appears after the request and is held one more cycle.
    if (r_req) begin
      if (fifo_q.size() > 0) r_data = fifo_q.pop_front();
      hold_data = 1'b1;
    end else if (hold_data) begin
      hold_data = 1'b0;
    end else begin
      r_data = 16'($urandom);
    end
    frame_start = fs_req || (fs_at_done && e.done && exp_ws == fs_at_ws);
    fs_req = 1'b0;
    r_empty = (fifo_q.size() == 0);

    exp_fd = 1'b0;
    if (frame_start) begin
      exp_ws = 17'd0;
    end else if (e.done) begin
      exp_ws = exp_ws + 17'd1;
      exp_fd = (exp_ws == IMG);
    end
    if (idle_c) begin
`ifdef FRAME_HEADER_EN
      if (m_pending) begin
        m_pending = 1'b0;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        for (int c = 1; c < B; c++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        for (int i = 1; i < 10; i++)
          for (int c = 0; c < B; c++)
            exp_q.push_back('{(i == 9) ? 1'b1 : (((8'h01 >> (i - 1)) & 8'h01) != 0), 1'b0, 1'b1, 1'b0});
        sched_byte(8'hFE, 1'b0);
      end else
`endif
      if (fifo_q.size() > 0) begin
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        sched_byte(fifo_q[0][15:8], 1'b0);
        sched_byte(fifo_q[0][7:0], 1'b1);
      end
    end
`ifdef FRAME_HEADER_EN
    if (frame_start) m_pending = 1'b1;
`endif
  endtask

  initial begin
    logic [19:0] lit;
    int          rq[$];
    int          cnt;
    int          k;

    repeat (3) @(negedge S_CLK);
    chk1("reset_uart_tx", uart_tx, 1'b1);
    chk1("reset_r_req", r_req, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk17("reset_words_sent", words_sent, 17'd0);
    chk1("reset_frame_done", frame_done, 1'b0);
    RST_N = 1'b1;

    // 0xA55A: 0xA5 then 0x5A, LSB first, each framed start/stop.
    lit = 20'b0101001011_0010110101;
    fifo_q.push_back(16'hA55A);
    step();
    step();
    chk1("t1_r_req_pulse", r_req, 1'b1);
    step();
    for (int i = 0; i < 20; i++)
      for (int c = 0; c < B; c++) begin
        step();
        if (c == 1) chk1("t1_line_bit", uart_tx, lit[19 - i]);
      end
    step();
    chk17("t1_words_sent", words_sent, 17'd1);

    // Three back-to-back words.
    fs_req = 1'b1;
    step();
    fifo_q.push_back(16'h0000);
    fifo_q.push_back(16'hFFFF);
    fifo_q.push_back(16'h1234);
    for (int i = 0; i < 3 * (20 * B + 3) + 100; i++) begin
      step();
      if (r_req) rq.push_back(cyc);
    end
    chk17("t2_r_req_count", 17'(rq.size()), 17'd3);
    if (rq.size() == 3) begin
      chk17("t2_period_a", 17'(rq[1] - rq[0]), 17'd83);
      chk17("t2_period_b", 17'(rq[2] - rq[1]), 17'd83);
    end
    chk17("t2_words_sent", words_sent, 17'd3);

    // Empty FIFO: line stays idle.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!uart_tx || busy || r_req) cnt++;
    end
    chk17("t3_idle_activity", 17'(cnt), 17'd0);

    // Asynchronous reset during bit 5 of the low byte.
    fifo_q.push_back(16'hC3C3);
    k = 0;
    while (exp_q.size() != 5 * B - 1 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) timeout("t4_reach_send_lo");
    #2;
    RST_N = 1'b0;
    #1;
    chk1("t4_async_uart_tx", uart_tx, 1'b1);
    chk1("t4_async_r_req", r_req, 1'b0);
    chk1("t4_async_busy", busy, 1'b0);
    chk17("t4_async_words_sent", words_sent, 17'd0);
    chk1("t4_async_frame_done", frame_done, 1'b0);
    exp_q.delete();
    exp_ws = 17'd0;
    exp_fd = 1'b0;
    m_pending = 1'b0;
    repeat (3) @(negedge S_CLK);
    RST_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!uart_tx || busy) cnt++;
    end
    chk17("t4_no_residual", 17'(cnt), 17'd0);

    // Frame of 4 words, then a frame_start colliding with the 4th increment.
    fs_req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
    cnt = 0;
    for (int i = 0; i < 4 * (20 * B + 3) + 100; i++) begin
      step();
      if (frame_done) cnt++;
    end
    chk17("t5_frame_done_count", 17'(cnt), 17'd1);
    chk17("t5_words_sent", words_sent, 17'd4);
    fs_req = 1'b1;
    step();
    fs_at_done = 1'b1;
    fs_at_ws = 17'd3;
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
    cnt = 0;
    for (int i = 0; i < 4 * (20 * B + 3) + 100; i++) begin
      step();
      if (frame_done) cnt++;
    end
    fs_at_done = 1'b0;
    chk17("t5_collide_frame_done", 17'(cnt), 17'd0);
    chk17("t5_collide_words_sent", words_sent, 17'd0);

`ifdef FRAME_HEADER_EN
    fs_req = 1'b1;
    fifo_q.push_back(16'h1234);
    for (int i = 0; i < 4 * 10 * B + 100; i++) step();
    chk17("t6_header_words_sent", words_sent, 17'd1);
`endif

    // Randomized traffic with occasional frame starts.
    for (int i = 0; i < 4000; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 19) == 0) fifo_q.push_back(16'($urandom));
      if ($urandom_range(0, 299) == 0) fs_req = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
